// File: rtl/mem_port_arbiter_if.sv
// Purpose: requester/memory bundle shared by mem_port_arbiter and its users.
// Latency: none; this is wiring only.
// Backpressure: request levels are held until the matching one-cycle ack.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    // Arbiter side: sees requests and memory read data, drives acks and memory.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, d_ack, rd_data, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester/memory side: the mirror image of the arbiter.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, d_ack, rd_data, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin sharing of one single-port memory between fetch and data requesters.
// Latency: request seen in IDLE at cycle 0, memory driven cycles 1..MEM_LAT, ack at MEM_LAT+1.
// Backpressure: requester holds req until its one-cycle ack; requests are sampled only in IDLE.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2     // 1..15, fits the 4-bit access counter
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic G_IF = 1'b0;
    localparam logic G_D  = 1'b1;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          grant;
    logic          last_grant;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rd_q;

    logic          any_req;
    logic          pick_d;

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        any_req = bus.if_req | bus.d_req;
        pick_d  = bus.d_req & (~bus.if_req | (last_grant == G_IF));
    end

    // Access sequencer: latch the winner's request, count memory cycles, then ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            grant      <= G_IF;
            last_grant <= G_D;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick_d;
                        last_grant <= pick_d;
                        cnt        <= CNT_INIT;
                        state      <= ACCESS;
                        if (pick_d) begin
                            we_q    <= bus.d_we;
                            addr_q  <= bus.d_addr;
                            wdata_q <= bus.d_wdata;
                        end else begin
                            // Fetches never write, so the write path is parked at zero.
                            we_q    <= 1'b0;
                            addr_q  <= bus.if_addr;
                            wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Read data is only valid in the last access cycle; stores leave rd_data alone.
                        if (!we_q) begin
                            rd_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode: memory strobes only while accessing, acks only in RESP.
    always_comb begin
        bus.mem_en    = (state == ACCESS);
        bus.mem_we    = (state == ACCESS) & we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.rd_data   = rd_q;
        bus.if_ack    = (state == RESP) & (grant == G_IF);
        bus.d_ack     = (state == RESP) & (grant == G_D);
        bus.busy      = (state != IDLE);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed scoreboard bench for mem_port_arbiter (MEM_LAT=2 and MEM_LAT=1 instances).
// Latency: expected ack cycle is pushed with each request and checked by the monitors.
// Backpressure: requests are held until their RESP cycle, then dropped.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic        port;   // 0 = IF, 1 = D
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    mem_port_arbiter_if #(.AW(32), .DW(32)) a ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) b ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    function automatic logic [31:0] mem_model(input logic [31:0] ad);
        if (ad == 32'h40) return 32'h8C010004;
        if (ad == 32'h10) return 32'h12345678;
        return ad ^ 32'hA5A50000;
    endfunction

    assign a.mem_rdata = mem_model(a.mem_addr);
    assign b.mem_rdata = mem_model(b.mem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, ex, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_a();
        chk("rst_if_ack",    32'(a.if_ack),  0);
        chk("rst_d_ack",     32'(a.d_ack),   0);
        chk("rst_rd_data",   a.rd_data,      0);
        chk("rst_mem_en",    32'(a.mem_en),  0);
        chk("rst_mem_we",    32'(a.mem_we),  0);
        chk("rst_mem_addr",  a.mem_addr,     0);
        chk("rst_mem_wdata", a.mem_wdata,    0);
        chk("rst_busy",      32'(a.busy),    0);
    endtask

    // Monitor for the MEM_LAT=2 instance.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst && (a.if_ack || a.d_ack)) begin
            chk("A_both_ack", 32'(a.if_ack & a.d_ack), 0);
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL A_unexpected_ack: if_ack=%0b d_ack=%0b expected none (cycle %0d)", a.if_ack, a.d_ack, cyc);
            end else begin
                e = qa.pop_front();
                chk("A_ack_port",  32'(a.d_ack), 32'(e.port));
                chk("A_rd_data",   a.rd_data,    e.rd);
                chk("A_ack_cycle", cyc,          e.cyc);
            end
        end
    end

    // Monitor for the MEM_LAT=1 instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst && (b.if_ack || b.d_ack)) begin
            chk("B_both_ack", 32'(b.if_ack & b.d_ack), 0);
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL B_unexpected_ack: if_ack=%0b d_ack=%0b expected none (cycle %0d)", b.if_ack, b.d_ack, cyc);
            end else begin
                e = qb.pop_front();
                chk("B_ack_port",  32'(b.d_ack), 32'(e.port));
                chk("B_rd_data",   b.rd_data,    e.rd);
                chk("B_ack_cycle", cyc,          e.cyc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        rst = 1'b0;
        a.if_req = 0; a.if_addr = '0; a.d_req = 0; a.d_we = 0; a.d_addr = '0; a.d_wdata = '0;
        b.if_req = 0; b.if_addr = '0; b.d_req = 0; b.d_we = 0; b.d_addr = '0; b.d_wdata = '0;
        step(1);
        chk_reset_a();
        rst = 1'b1;
        step(2);

        // Single fetch of 0x40.
        k = cyc;
        a.if_req = 1; a.if_addr = 32'h40;
        qa.push_back('{1'b0, 32'h8C010004, k + 3});
        for (int i = 1; i <= 2; i++) begin
            step(1);
            chk("fetch_mem_en",   32'(a.mem_en), 1);
            chk("fetch_mem_addr", a.mem_addr,    32'h40);
            chk("fetch_mem_we",   32'(a.mem_we), 0);
        end
        step(1);
        chk("fetch_resp_mem_en", 32'(a.mem_en), 0);
        a.if_req = 0;
        step(1);
        chk("fetch_busy_done", 32'(a.busy), 0);

        // Store; rd_data must keep the fetched word.
        k = cyc;
        a.d_req = 1; a.d_we = 1; a.d_addr = 32'h100; a.d_wdata = 32'hDEADBEEF;
        qa.push_back('{1'b1, 32'h8C010004, k + 3});
        for (int i = 1; i <= 2; i++) begin
            step(1);
            chk("store_mem_we",    32'(a.mem_we), 1);
            chk("store_mem_wdata", a.mem_wdata,   32'hDEADBEEF);
            chk("store_mem_addr",  a.mem_addr,    32'h100);
        end
        step(1);
        chk("store_resp_mem_we", 32'(a.mem_we), 0);
        a.d_req = 0; a.d_we = 0;
        step(1);

        // Tie with both held: IF, D, IF, D with acks four cycles apart.
        k = cyc;
        a.if_req = 1; a.if_addr = 32'h40;
        a.d_req = 1;  a.d_we = 0; a.d_addr = 32'h200;
        qa.push_back('{1'b0, 32'h8C010004, k + 3});
        qa.push_back('{1'b1, 32'hA5A50200, k + 7});
        qa.push_back('{1'b0, 32'h8C010004, k + 11});
        qa.push_back('{1'b1, 32'hA5A50200, k + 15});
        step(15);
        a.if_req = 0; a.d_req = 0;
        step(1);

        // Isolation: D arrives and changes address while IF is accessing.
        k = cyc;
        a.if_req = 1; a.if_addr = 32'h300;
        qa.push_back('{1'b0, 32'hA5A50300, k + 3});
        step(1);
        a.d_req = 1; a.d_addr = 32'h500;
        chk("iso_mem_addr1", a.mem_addr, 32'h300);
        step(1);
        a.d_addr = 32'h600;
        chk("iso_mem_addr2", a.mem_addr, 32'h300);
        qa.push_back('{1'b1, 32'hA5A50600, k + 7});
        step(1);
        a.if_req = 0;
        step(4);
        a.d_req = 0;
        step(1);

        // Reset during the second access cycle: outputs clear, ack is lost.
        a.if_req = 1; a.if_addr = 32'h40;
        step(2);
        rst = 1'b0;
        #1;
        chk_reset_a();
        a.if_req = 0;
        step(1);
        rst = 1'b1;
        step(4);
        chk("post_rst_busy", 32'(a.busy), 0);
        k = cyc;
        a.if_req = 1; a.if_addr = 32'h10;
        qa.push_back('{1'b0, 32'h12345678, k + 3});
        step(3);
        a.if_req = 0;
        step(2);

        // MEM_LAT=1: a single access cycle, ack in cycle 2.
        k = cyc;
        b.if_req = 1; b.if_addr = 32'h10;
        qb.push_back('{1'b0, 32'h12345678, k + 2});
        step(1);
        chk("lat1_mem_en",   32'(b.mem_en), 1);
        chk("lat1_mem_addr", b.mem_addr,    32'h10);
        step(1);
        chk("lat1_resp_mem_en", 32'(b.mem_en), 0);
        b.if_req = 0;
        step(3);

        chk("A_queue_empty", 32'(qa.size()), 0);
        chk("B_queue_empty", 32'(qb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
